// File: rtl/fpu_sched_pkg.sv
// Shared types for the round-robin FPU scheduler: FSM states and FPU OpSel encodings.
package fpu_sched_pkg;

    localparam int unsigned OP_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    localparam logic [OP_W-1:0] OP_ADD = 2'b00;
    localparam logic [OP_W-1:0] OP_SUB = 2'b01;
    localparam logic [OP_W-1:0] OP_MUL = 2'b10;
    localparam logic [OP_W-1:0] OP_DIV = 2'b11;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx
);

    int unsigned     pos;
    logic [ID_W-1:0] sel;
    logic            found;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        sel   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            pos = 32'(ptr) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            sel = ID_W'(pos);
            if (!found && req[sel]) begin
                found      = 1'b1;
                grant[sel] = 1'b1;
                idx        = sel;
            end
        end
    end

endmodule

// File: rtl/fpu_rr_scheduler.sv
// Shares one FPU between NUM_REQ requesters: round-robin grant, held operands,
// and a single tagged response channel with backpressure.
module fpu_rr_scheduler
    import fpu_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned FPU_LAT = 1,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_a,
    input  logic [NUM_REQ*DATA_W-1:0] req_b,
    input  logic [NUM_REQ*OP_W-1:0]   req_op,
    output logic [DATA_W-1:0]         fpu_a,
    output logic [DATA_W-1:0]         fpu_b,
    output logic [OP_W-1:0]           fpu_opsel,
    input  logic [DATA_W-1:0]         fpu_result,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      busy
);

    localparam int unsigned CNT_W = (FPU_LAT > 1) ? $clog2(FPU_LAT) : 1;

    state_t             state;
    state_t             next_state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    win_idx;
    logic [NUM_REQ-1:0] grant;
    logic [CNT_W-1:0]   lat_cnt;
    logic               any_req;

    assign any_req = |req_valid;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant),
        .idx   (win_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (any_req) next_state = ISSUE;
            ISSUE:   if (lat_cnt == '0) next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = '0;
        rsp_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE:    req_ready = rst ? '0 : grant;
            ISSUE:   busy = 1'b1;
            RESP: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // Operand capture on accept; result sampled once the FPU latency has elapsed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            lat_cnt   <= '0;
            fpu_a     <= '0;
            fpu_b     <= '0;
            fpu_opsel <= '0;
            rsp_id    <= '0;
            rsp_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        fpu_a     <= req_a[int'(win_idx)*DATA_W +: DATA_W];
                        fpu_b     <= req_b[int'(win_idx)*DATA_W +: DATA_W];
                        fpu_opsel <= req_op[int'(win_idx)*OP_W +: OP_W];
                        rsp_id    <= win_idx;
                        rr_ptr    <= (win_idx == ID_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
                        lat_cnt   <= CNT_W'(FPU_LAT-1);
                    end
                end
                ISSUE: begin
                    if (lat_cnt == '0) begin
                        rsp_data <= fpu_result;
                    end else begin
                        lat_cnt <= lat_cnt - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
